// File: rtl/enable_sequencer_if.sv
// Bus between the trigger source and the enable sequencer: trigger/config
// inputs toward the sequencer, enable bus and status flags back out.
interface enable_sequencer_if #(
    parameter int N  = 4,
    parameter int HW = 8
);
    localparam int SW = $clog2(N + 1);

    logic          trg;
    logic          mode;
    logic [HW-1:0] hold;
    logic          abort;
    logic [N-1:0]  ena;
    logic [SW-1:0] step;
    logic          busy;
    logic          done;
    logic          ovr;

    modport master (
        output trg, mode, hold, abort,
        input  ena, step, busy, done, ovr
    );

    modport slave (
        input  trg, mode, hold, abort,
        output ena, step, busy, done, ovr
    );
endinterface

// File: rtl/enable_sequencer.sv
// Trigger-edge driven thermometer enable sequencer with programmable step hold.
// Optional abort support is compiled in when SEQ_ABORT_EN is defined.
module enable_sequencer #(
    parameter int N  = 4,
    parameter int HW = 8
) (
    input  logic          clk,
    input  logic          rst,
    enable_sequencer_if.slave bus
);
    localparam int SW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e        state_q, state_d;
    logic          trg_q, trg_d;
    logic          mode_q, mode_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [HW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  ena_q, ena_d;
    logic [SW-1:0] step_q, step_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;
    logic          trg_edge;
    logic          start;

    // SHRINK clears low bits as s grows; GROW fills from bit 0 upward.
    function automatic logic [N-1:0] pattern(input logic grow, input logic [SW-1:0] s);
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) begin
            p[i] = grow ? (i < int'(s)) : (i >= int'(s) - 1);
        end
        return p;
    endfunction

    assign trg_edge = bus.trg & ~trg_q;
    assign trg_d    = bus.trg;

`ifdef SEQ_ABORT_EN
    assign start = trg_edge & ~bus.abort;
`else
    assign start = trg_edge;
    logic unused_abort;
    assign unused_abort = bus.abort;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
        state_d = state_q;
        mode_d  = mode_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        ena_d   = ena_q;
        step_d  = step_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovr_d   = trg_edge && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    mode_d  = bus.mode;
                    hold_d  = bus.hold;
                    cnt_d   = '0;
                    step_d  = SW'(1);
                    ena_d   = pattern(bus.mode, SW'(1));
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
`ifdef SEQ_ABORT_EN
                if (bus.abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ena_d   = '0;
                    step_d  = '0;
                    busy_d  = 1'b0;
                end else
`endif
                if (cnt_q == hold_q) begin
                    cnt_d = '0;
                    if (step_q == SW'(N)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        ena_d   = '0;
                        step_d  = '0;
                        busy_d  = 1'b0;
                    end else begin
                        step_d = step_q + SW'(1);
                        ena_d  = pattern(mode_q, step_q + SW'(1));
                    end
                end else begin
                    cnt_d = cnt_q + HW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                ena_d   = '0;
                step_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            trg_q   <= 1'b0;
            mode_q  <= 1'b0;
            hold_q  <= '0;
            cnt_q   <= '0;
            ena_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            trg_q   <= trg_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            ena_q   <= ena_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.ena  = ena_q;
    assign bus.step = step_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.ovr  = ovr_q;
endmodule

// File: tb/tb_enable_sequencer.sv
// Directed bench for enable_sequencer (N=4, HW=8): vector table plus
// hand-written multi-cycle sequences for retrigger and hold-change cases.
module tb_enable_sequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    enable_sequencer_if #(.N(4), .HW(8)) bus ();

    enable_sequencer #(.N(4), .HW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       trg;
        logic       mode;
        logic [7:0] hold;
        logic       abort;
        logic [3:0] ena;
        logic [2:0] step;
        logic       busy;
        logic       done;
        logic       ovr;
    } vec_t;

    vec_t vecs[$];

    logic [3:0] shrink_tab [0:4];
    logic [3:0] grow_tab   [0:4];

    function automatic void add(input logic r, input logic t, input logic m, input logic [7:0] h,
                                input logic a, input logic [3:0] e, input logic [2:0] s,
                                input logic b, input logic d, input logic o);
        vecs.push_back('{r, t, m, h, a, e, s, b, d, o});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e, input int s,
                             input logic b, input logic d, input logic o);
        check({tag, ".ena"},  int'(bus.ena),  int'(e));
        check({tag, ".step"}, int'(bus.step), s);
        check({tag, ".busy"}, int'(bus.busy), int'(b));
        check({tag, ".done"}, int'(bus.done), int'(d));
        check({tag, ".ovr"},  int'(bus.ovr),  int'(o));
    endtask

    task automatic apply(input logic r, input logic t, input logic m, input logic [7:0] h, input logic a);
        rst       = r;
        bus.trg   = t;
        bus.mode  = m;
        bus.hold  = h;
        bus.abort = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e_ena;
        int         e_step;
        logic       e_busy, e_done, e_ovr;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.trg = 1'b0;
        bus.mode = 1'b0;
        bus.hold = '0;
        bus.abort = 1'b0;
        shrink_tab[0] = 4'b0000; shrink_tab[1] = 4'b1111; shrink_tab[2] = 4'b1110;
        shrink_tab[3] = 4'b1100; shrink_tab[4] = 4'b1000;
        grow_tab[0]   = 4'b0000; grow_tab[1]   = 4'b0001; grow_tab[2]   = 4'b0011;
        grow_tab[3]   = 4'b0111; grow_tab[4]   = 4'b1111;

        // SHRINK, hold=0, after reset
        add(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 4'b1111, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 4'b1110, 2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 4'b1100, 3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 4'b1000, 4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        // GROW, hold=2: three cycles per step
        add(0, 1, 1, 2, 0, 4'b0001, 1, 1, 0, 0);
        add(0, 0, 1, 2, 0, 4'b0001, 1, 1, 0, 0);
        add(0, 0, 1, 2, 0, 4'b0001, 1, 1, 0, 0);
        add(0, 0, 1, 2, 0, 4'b0011, 2, 1, 0, 0);
        add(0, 0, 1, 2, 0, 4'b0011, 2, 1, 0, 0);
        add(0, 0, 1, 2, 0, 4'b0011, 2, 1, 0, 0);
        add(0, 0, 1, 2, 0, 4'b0111, 3, 1, 0, 0);
        add(0, 0, 1, 2, 0, 4'b0111, 3, 1, 0, 0);
        add(0, 0, 1, 2, 0, 4'b0111, 3, 1, 0, 0);
        add(0, 0, 1, 2, 0, 4'b1111, 4, 1, 0, 0);
        add(0, 0, 1, 2, 0, 4'b1111, 4, 1, 0, 0);
        add(0, 0, 1, 2, 0, 4'b1111, 4, 1, 0, 0);
        add(0, 0, 1, 2, 0, 4'b0000, 0, 0, 1, 0);
        add(0, 0, 1, 2, 0, 4'b0000, 0, 0, 0, 0);
        // reset at step 3, no done, then restart
        add(0, 1, 0, 0, 0, 4'b1111, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 4'b1110, 2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 4'b1100, 3, 1, 0, 0);
        add(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 4'b1111, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 4'b1110, 2, 1, 0, 0);
        // trg held high through reset release starts a sequence
        add(1, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 4'b1111, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        // edge during DONE: ignored, ovr pulses
        add(0, 1, 0, 0, 0, 4'b1111, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 4'b1110, 2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 4'b1100, 3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 4'b1000, 4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        // abort at step 2
        add(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 4'b1111, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 4'b1110, 2, 1, 0, 0);
`ifdef SEQ_ABORT_EN
        add(0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
`else
        add(0, 0, 0, 0, 1, 4'b1100, 3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 4'b1000, 4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 4'b1111, 1, 1, 0, 0);
        add(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].trg, vecs[i].mode, vecs[i].hold, vecs[i].abort);
            check_out($sformatf("vec%0d", i), vecs[i].ena, int'(vecs[i].step),
                      vecs[i].busy, vecs[i].done, vecs[i].ovr);
        end

        // Long trg level plus a second edge during RUN (SHRINK, hold=9)
        apply(1, 0, 0, 0, 0);
        check_out("retrig.rst", 4'b0000, 0, 0, 0, 0);
        for (int c = 0; c < 45; c++) begin
            apply(0, (c != 20), 0, 8'd9, 0);
            e_ena = 4'b0000; e_step = 0; e_busy = 0; e_done = 0;
            if (c < 40) begin
                e_step = c / 10 + 1;
                e_ena  = shrink_tab[e_step];
                e_busy = 1'b1;
            end else if (c == 40) begin
                e_done = 1'b1;
            end
            e_ovr = (c == 21);
            check_out($sformatf("retrig.c%0d", c), e_ena, e_step, e_busy, e_done, e_ovr);
        end

        // Back-to-back start in the IDLE cycle after DONE; hold changed mid-run
        apply(1, 0, 0, 0, 0);
        check_out("b2b.rst", 4'b0000, 0, 0, 0, 0);
        for (int c = 0; c < 40; c++) begin
            apply(0, (c == 0 || c == 14), 1, (c < 4) ? 8'd2 : 8'd5, 0);
            e_ena = 4'b0000; e_step = 0; e_busy = 0; e_done = 0;
            if (c <= 11) begin
                e_step = c / 3 + 1;
                e_busy = 1'b1;
            end else if (c == 12 || c == 38) begin
                e_done = 1'b1;
            end else if (c >= 14 && c <= 37) begin
                e_step = (c - 14) / 6 + 1;
                e_busy = 1'b1;
            end
            e_ena = grow_tab[e_step];
            check_out($sformatf("b2b.c%0d", c), e_ena, e_step, e_busy, e_done, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/enable_sequencer.md
Name: enable_sequencer

Overview:
- Parametrised, single-clock successor to the trigger-driven enable-sequencing logic.
- On a trigger rising edge, steps an N-channel enable bus through N thermometer patterns, each held for a programmable number of cycles.
- Flags completion, and flags retriggers that arrive while a sequence is running.
- Sits between the trigger source and the N gated downstream stages.

Parameters:
- N, 4, number of enable channels (legal range 2..16).
- HW, 8, width of the hold-count input.
- SW, derived localparam, equal to $clog2(N+1); width of the step output.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- trg  input  1  trigger level; a sequence starts on its rising edge.
- mode  input  1  pattern select: 0 = SHRINK, 1 = GROW. Sampled at start.
- hold  input  HW  extra cycles per step; each step lasts hold+1 cycles. Sampled at start.
- abort  input  1  abort request. Used only when SEQ_ABORT_EN is defined.
- ena  output  N  enable bus.
- step  output  SW  current step number, 1..N; 0 when idle.
- busy  output  1  high while a sequence is running.
- done  output  1  one-cycle pulse when a sequence completes normally.
- ovr  output  1  one-cycle pulse when a trigger edge arrives while busy.

Behaviour:
- Reset and clocking: one clock (clk); reset (rst) is synchronous and active-high. While rst=1 at a clk edge, all outputs clear to 0: ena=0, step=0, busy=0, done=0, ovr=0. The internal trg_q register, the hold counter and the latched mode/hold also clear to 0. rst takes priority over every other event.
- Edge detect: trg_q is trg registered. An edge exists when trg=1 and trg_q=0. A level held high does not restart a sequence.
- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs: ena=0, step=0, busy=0.
  - An edge in cycle k latches mode and hold. From cycle k+1: state=RUN, step=1, busy=1, ena = pattern(1).
- RUN:
  - The hold counter counts 0..hold_l. When it reaches hold_l, step increments and the counter returns to 0.
  - When step=N and the counter reaches hold_l, the next state is DONE.
  - Total RUN time is N*(hold_l+1) cycles.
- DONE: lasts 1 cycle. done=1, ena=0, step=0, busy=0. Next state is IDLE.
- Patterns for step s, with bit i of ena:
  - SHRINK: ena[i]=1 iff i >= s-1. Step 1 is all ones; step N has only bit N-1 set.
  - GROW: ena[i]=1 iff i < s. Step 1 has bit 0 set; step N is all ones.
- Registering: ena, step, busy and done are registered with no combinational path from inputs. ovr is also registered.
- Retrigger:
  - An edge while in RUN or DONE is ignored for sequencing.
  - ovr pulses for 1 cycle in the cycle after the edge.
  - The running sequence is unaffected.
- Restart after DONE: an edge that arrives in the IDLE cycle immediately following DONE starts a new sequence normally.
- Mid-run changes: changes to mode or hold during RUN have no effect until the next start.
- hold=0: each step lasts 1 cycle. This is legal.
- Reset mid-run: the next cycle is IDLE with all outputs 0 and no done pulse.
  - trg_q also clears, so a trg held high through the reset release produces an edge and starts a sequence on the first post-reset cycle.

Optional Feature:
- SEQ_ABORT_EN defined:
  - abort=1 sampled in RUN forces IDLE on the next cycle: ena=0, step=0, busy=0.
  - No done pulse is generated.
  - If abort and an edge arrive in the same IDLE cycle, abort has priority and no sequence starts.
- SEQ_ABORT_EN undefined:
  - The abort port exists but is ignored, and no abort logic is synthesised.
  - A sequence always runs to DONE unless rst is asserted.

Test Plan:
1. N=4, mode=0, hold=0; reset, then one trg rising edge -> ena = 1111, 1110, 1100, 1000 on consecutive cycles. Then done=1 with ena=0000 for 1 cycle, then IDLE.
2. N=4, mode=1, hold=2 -> ena = 0001, 0011, 0111, 1111, each held 3 cycles. busy is high for 12 cycles. step reads 1,1,1,2,2,2,3,3,3,4,4,4.
3. trg held high for 20 cycles, then a second edge during RUN -> exactly one sequence runs. ovr=1 for 1 cycle after the second edge, and the step timing is unchanged.
4. Assert rst at step 3 of a running sequence -> next cycle: ena=0, busy=0, step=0, and done never pulses. A fresh edge then restarts the sequence from step 1.
5. Edge in the IDLE cycle right after DONE -> a new sequence starts. hold changed mid-run from 2 to 5 -> the current run keeps 3-cycle steps, and the next run uses 6-cycle steps.
6. SEQ_ABORT_EN defined: abort=1 at step 2 -> next cycle IDLE with ena=0 and no done pulse. Macro undefined: same stimulus -> the sequence completes and done pulses.
